qam_err_stats: RTL and testbench
================================

// Module: qam_err_stats
// PURPOSE
//  16-QAM in-phase error statistics for the MOD465 modem measurement chain.
//  Slices each in-phase symbol sample to the nearest 4-level reference.
//  Accumulates the slicer error, and its square, over one LFSR period.
//  Publishes the period means: DC error (offset) and mean-squared error (MSE).
//  Sits after mapper_16_qam and is clocked by the 25 MHz system clock with the symbol enable.
// PARAMETERS
//  REF_LEVEL  18'sd32768  inner decision level a, s1.17 format (0.25); outer level is 3a
//  ACC_LOG2   20          log2 of averaging length; period mean = acc >>> ACC_LOG2
// PORTS
//  clk                 in   1       system clock; single clock domain
//  reset               in   1       synchronous, active-high; clears all state
//  sym_clk_en          in   1       symbol-rate enable; all state advances only when high
//  cycle_out_periodic  in   1       period strobe; honoured only together with sym_clk_en
//  in_phs_sig          in   18 s    in-phase sample, s1.17
//  acc_dc_err_out      out  18 s    mean error over last period, s1.17
//  acc_sq_err_out      out  18 s    mean squared error over last period, s1.17
// BEHAVIOUR
//  - Reset: all pipeline regs, accumulators and outputs = 0. Reset wins over enable.
//    A reset mid-period discards the partial sums.
//  - Slicer (combinational on in_phs_sig = x):
//      x >= 2a          -> +3a
//      0 <= x < 2a      -> +a
//      -2a <= x < 0     -> -a
//      x < -2a          -> -3a
//    Tie at 0 goes to +a; tie at 2a goes to +3a.
//  - Error stage, on sym_clk_en: e_r <= x - slice(x).
//    18-bit signed; no overflow is possible since |e| <= a.
//  - Square stage, on sym_clk_en:
//    p = e_r*e_r is a 36-bit signed full product.
//    sq_r <= p[34:17] (s1.17, always >= 0).
//  - Accumulators:
//    dc_acc and sq_acc are signed, width 18+ACC_LOG2+2.
//    Inputs are sign-extended (e_r, sq_r).
//  - On sym_clk_en with cycle_out_periodic = 0:
//    dc_acc += e_r; sq_acc += sq_r.
//  - On sym_clk_en with cycle_out_periodic = 1:
//    acc_dc_err_out <= dc_acc >>> ACC_LOG2 (low 18 bits).
//    acc_sq_err_out <= sq_acc >>> ACC_LOG2 (low 18 bits).
//    dc_acc <= e_r and sq_acc <= sq_r, so the boundary sample starts the new period.
//  - sym_clk_en = 0: every register holds. A strobe without the enable is ignored.
//  - Latency: x to dc_acc is 1 enable; x to sq_acc is 2 enables.
//    Period boundaries are fixed-offset by these latencies; no realignment.
//  - Outputs are registered and hold between strobes.
//    Before the first strobe the outputs are 0.
//  - Truncating shift (floor). With a 2^N-1 symbol LFSR period, the small bias is accepted.
// CONFIGURATION
//  ERR_SQ_EN defined:
//    Square stage and sq_acc are built; acc_sq_err_out behaves as above.
//  ERR_SQ_EN undefined:
//    sq_r, the multiplier and sq_acc are removed.
//    acc_sq_err_out is constant 0.
//    The DC path is unchanged, bit- and cycle-exact.
// TESTING (ACC_LOG2=4, strobe every 16th enable, enable every 4 clk, ERR_SQ_EN defined)
//  - Reset held 5 clk with x=39322 and enable active:
//    outputs 0, and they stay 0 until the first post-reset strobe.
//  - x = +32768 (+a) constant:
//    every strobe gives dc=0, sq=0.
//  - x = 39322 (0.30) constant, after 2 full periods:
//    dc=6554, sq=327 (6554^2>>17).
//  - x = -104858 (-0.80) constant:
//    slice -98304, so dc=-6554, sq=327.
//  - Boundary inputs:
//    x=0 slices to +a, giving dc=-32768.
//    x=65536 slices to +3a, giving dc=-32768.
//  - Strobe driven with sym_clk_en=0 -> no output change.
//    Reset asserted mid-period -> next strobe's mean counts post-reset samples only.

Source files
------------

// File: rtl/qam_err_stats.sv
// qam_err_stats: 16-QAM in-phase slicer error statistics.
// Slices each in-phase sample to the nearest of four reference levels,
// accumulates the slicer error (and optionally its square) over one
// averaging period, and publishes the period means on each period strobe.
// Build option: define ERR_SQ_EN to build the squared-error path; without it
// acc_sq_err_out is tied to zero and only the DC error path exists.
module qam_err_stats #(
    parameter logic signed [17:0] REF_LEVEL = 18'sd32768,
    parameter int                 ACC_LOG2  = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sym_clk_en,
    input  logic               cycle_out_periodic,
    input  logic signed [17:0] in_phs_sig,
    output logic signed [17:0] acc_dc_err_out,
    output logic signed [17:0] acc_sq_err_out
);

    // Accumulator width leaves headroom for 2^ACC_LOG2 full-scale samples.
    localparam int ACC_W = 18 + ACC_LOG2 + 2;

    // Decision levels held in 19 bits so 2a and 3a never wrap.
    localparam logic signed [18:0] LVL_A  = 19'(REF_LEVEL);
    localparam logic signed [18:0] LVL_2A = LVL_A <<< 1;
    localparam logic signed [18:0] LVL_3A = LVL_A + LVL_2A;

    // Nearest-level slicer; ties at 0 and 2a resolve upward.
    function automatic logic signed [18:0] slice_level(input logic signed [18:0] x);
        logic signed [18:0] lvl;
        if (x >= LVL_2A) begin
            lvl = LVL_3A;
        end else if (x >= 19'sd0) begin
            lvl = LVL_A;
        end else if (x >= -LVL_2A) begin
            lvl = -LVL_A;
        end else begin
            lvl = -LVL_3A;
        end
        return lvl;
    endfunction

    // DC error path state
    logic signed [17:0]      e_q,         e_d;
    logic signed [ACC_W-1:0] dc_acc_q,    dc_acc_d;
    logic signed [17:0]      dc_out_q,    dc_out_d;

    // Combinational helpers
    logic signed [18:0]      x_ext_s;
    logic signed [18:0]      diff_s;
    logic signed [17:0]      err_s;
    logic signed [ACC_W-1:0] e_ext_s;
    logic signed [ACC_W-1:0] dc_mean_s;

    // Slicer error of the current sample and the floor-divided DC mean.
    always_comb begin
        x_ext_s   = {in_phs_sig[17], in_phs_sig};
        diff_s    = x_ext_s - slice_level(x_ext_s);
        err_s     = diff_s[17:0];
        e_ext_s   = {{(ACC_W-18){e_q[17]}}, e_q};
        dc_mean_s = dc_acc_q >>> ACC_LOG2;
    end

    // DC path next state: strobe publishes the mean and restarts the sum.
    always_comb begin
        e_d      = e_q;
        dc_acc_d = dc_acc_q;
        dc_out_d = dc_out_q;
        if (sym_clk_en) begin
            e_d = err_s;
            if (cycle_out_periodic) begin
                dc_out_d = dc_mean_s[17:0];
                dc_acc_d = e_ext_s;
            end else begin
                dc_acc_d = dc_acc_q + e_ext_s;
            end
        end else begin
            e_d      = e_q;
            dc_acc_d = dc_acc_q;
            dc_out_d = dc_out_q;
        end
    end

    // DC path registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q      <= 18'sd0;
            dc_acc_q <= '0;
            dc_out_q <= 18'sd0;
        end else begin
            e_q      <= e_d;
            dc_acc_q <= dc_acc_d;
            dc_out_q <= dc_out_d;
        end
    end

    assign acc_dc_err_out = dc_out_q;

`ifdef ERR_SQ_EN
    // Squared-error path state
    logic signed [17:0]      sq_q,        sq_d;
    logic signed [ACC_W-1:0] sq_acc_q,    sq_acc_d;
    logic signed [17:0]      sq_out_q,    sq_out_d;

    logic signed [35:0]      prod_s;
    logic signed [17:0]      sq_s;
    logic signed [ACC_W-1:0] sq_ext_s;
    logic signed [ACC_W-1:0] sq_mean_s;

    // Square of the registered error, rescaled to s1.17 (never negative).
    always_comb begin
        prod_s    = e_q * e_q;
        sq_s      = prod_s[34:17];
        sq_ext_s  = {{(ACC_W-18){sq_q[17]}}, sq_q};
        sq_mean_s = sq_acc_q >>> ACC_LOG2;
    end

    // Squared path next state, one enable behind the DC path.
    always_comb begin
        sq_d     = sq_q;
        sq_acc_d = sq_acc_q;
        sq_out_d = sq_out_q;
        if (sym_clk_en) begin
            sq_d = sq_s;
            if (cycle_out_periodic) begin
                sq_out_d = sq_mean_s[17:0];
                sq_acc_d = sq_ext_s;
            end else begin
                sq_acc_d = sq_acc_q + sq_ext_s;
            end
        end else begin
            sq_d     = sq_q;
            sq_acc_d = sq_acc_q;
            sq_out_d = sq_out_q;
        end
    end

    // Squared path registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sq_q     <= 18'sd0;
            sq_acc_q <= '0;
            sq_out_q <= 18'sd0;
        end else begin
            sq_q     <= sq_d;
            sq_acc_q <= sq_acc_d;
            sq_out_q <= sq_out_d;
        end
    end

    assign acc_sq_err_out = sq_out_q;

    // Bits of the wide intermediates that are intentionally dropped.
    logic unused_bits_s;
    assign unused_bits_s = ^{diff_s[18], dc_mean_s[ACC_W-1:18],
                             prod_s[35], prod_s[16:0], sq_mean_s[ACC_W-1:18]};
`else
    assign acc_sq_err_out = 18'sd0;

    // Bits of the wide intermediates that are intentionally dropped.
    logic unused_bits_s;
    assign unused_bits_s = ^{diff_s[18], dc_mean_s[ACC_W-1:18]};
`endif

endmodule

// File: tb/tb_qam_err_stats.sv
// Directed testbench for qam_err_stats with ACC_LOG2=4: strobe every 16th
// enable, enable every 4th clock. Expected means are hand-computed.
// Squared-error expectations collapse to 0 when ERR_SQ_EN is not defined.
module tb_qam_err_stats;

    logic               clk;
    logic               reset;
    logic               sym_clk_en;
    logic               cycle_out_periodic;
    logic signed [17:0] in_phs_sig;
    logic signed [17:0] acc_dc_err_out;
    logic signed [17:0] acc_sq_err_out;

    int checks_cnt;
    int fail_cnt;

`ifdef ERR_SQ_EN
    localparam bit SQ_ON = 1'b1;
`else
    localparam bit SQ_ON = 1'b0;
`endif

    qam_err_stats #(
        .REF_LEVEL (18'sd32768),
        .ACC_LOG2  (4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .sym_clk_en         (sym_clk_en),
        .cycle_out_periodic (cycle_out_periodic),
        .in_phs_sig         (in_phs_sig),
        .acc_dc_err_out     (acc_dc_err_out),
        .acc_sq_err_out     (acc_sq_err_out)
    );

    // 10 ns system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sq_exp(input int v);
        return SQ_ON ? v : 0;
    endfunction

    task automatic check_val(input string tag, input logic signed [17:0] got, input int exp);
        checks_cnt++;
        if (int'(got) != exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, int'(got), exp);
        end
    endtask

    // One symbol: enable high for one clock, then three idle clocks.
    task automatic step(input int x, input logic strb);
        in_phs_sig         = 18'(x);
        cycle_out_periodic = strb;
        sym_clk_en         = 1'b1;
        @(posedge clk); #1;
        sym_clk_en         = 1'b0;
        cycle_out_periodic = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // n-1 plain symbols followed by one strobed symbol.
    task automatic run_period(input int x, input int n);
        for (int i = 0; i < n - 1; i++) step(x, 1'b0);
        step(x, 1'b1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Reset, two full periods of constant x, check the settled means.
    task automatic run_const(input string tag, input int x, input int exp_dc, input int exp_sq);
        pulse_reset();
        run_period(x, 16);
        run_period(x, 16);
        check_val({tag, "_dc"}, acc_dc_err_out, exp_dc);
        check_val({tag, "_sq"}, acc_sq_err_out, sq_exp(exp_sq));
    endtask

    initial begin
        checks_cnt         = 0;
        fail_cnt           = 0;
        reset              = 1'b1;
        sym_clk_en         = 1'b1;
        cycle_out_periodic = 1'b0;
        in_phs_sig         = 18'sd39322;

        // Reset held 5 clocks with enable active
        repeat (5) @(posedge clk);
        #1;
        reset      = 1'b0;
        sym_clk_en = 1'b0;
        check_val("rst_dc", acc_dc_err_out, 0);
        check_val("rst_sq", acc_sq_err_out, 0);

        // Outputs stay 0 until the first strobe
        for (int i = 0; i < 15; i++) step(39322, 1'b0);
        check_val("pre_dc", acc_dc_err_out, 0);
        check_val("pre_sq", acc_sq_err_out, 0);

        // First strobe: 14 errors and 13 squares in the sums (pipeline fill)
        step(39322, 1'b1);
        check_val("p1_dc", acc_dc_err_out, 5734);
        check_val("p1_sq", acc_sq_err_out, sq_exp(265));

        // Full period
        run_period(39322, 16);
        check_val("p2_dc", acc_dc_err_out, 6554);
        check_val("p2_sq", acc_sq_err_out, sq_exp(327));

        // Strobe without enable mid-period must be ignored
        for (int i = 0; i < 5; i++) step(39322, 1'b0);
        cycle_out_periodic = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        cycle_out_periodic = 1'b0;
        check_val("nostb_dc", acc_dc_err_out, 6554);
        check_val("nostb_sq", acc_sq_err_out, sq_exp(327));
        for (int i = 0; i < 10; i++) step(39322, 1'b0);
        step(39322, 1'b1);
        check_val("p3_dc", acc_dc_err_out, 6554);
        check_val("p3_sq", acc_sq_err_out, sq_exp(327));

        // Mid-period reset discards the partial sums
        for (int i = 0; i < 7; i++) step(-104858, 1'b0);
        pulse_reset();
        check_val("mrst_dc", acc_dc_err_out, 0);
        check_val("mrst_sq", acc_sq_err_out, 0);
        run_period(-104858, 16);
        check_val("mp1_dc", acc_dc_err_out, -5735);
        check_val("mp1_sq", acc_sq_err_out, sq_exp(265));
        run_period(-104858, 16);
        check_val("mp2_dc", acc_dc_err_out, -6554);
        check_val("mp2_sq", acc_sq_err_out, sq_exp(327));

        // Constant-input and slicer-boundary cases
        run_const("pos_a",   32768,      0,    0);
        run_const("x_zero",  0,     -32768, 8192);
        run_const("x_2a",    65536, -32768, 8192);
        run_const("x_2a_m1", 65535,  32767, 8191);
        run_const("x_m2a",  -65536, -32768, 8192);
        run_const("x_m2a_m1", -65537, 32767, 8191);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
